// File: rtl/lsu_arbiter_if.sv
// Requester-side command/response bundle for lsu_arbiter.
// master = requester (core LSU path, DMA, debug); slave = the arbiter.
interface lsu_arbiter_if;
    logic        req;
    logic        we;
    logic        ld_us;
    logic [3:0]  byte_num;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, ld_us, byte_num, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, ld_us, byte_num, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/lsu_arbiter.sv
// Two-requester arbiter in front of the single LSU port: IDLE -> ISSUE -> RESP.
// Define LSU_ARB_STAT_EN to add saturating 16-bit per-requester grant counters.
module lsu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    lsu_arbiter_if.slave       m0,
    lsu_arbiter_if.slave       m1,
    output logic               lsu_sten_o,
    output logic               lsu_ld_us_o,
    output logic [3:0]         lsu_byte_num_o,
    output logic [31:0]        lsu_addr_o,
    output logic [31:0]        lsu_st_data_o,
    input  logic [31:0]        lsu_ld_data_i
`ifdef LSU_ARB_STAT_EN
    ,
    output logic [15:0]        m0_cnt_o,
    output logic [15:0]        m1_cnt_o
`endif
);

    typedef struct packed {
        logic        we;
        logic        ld_us;
        logic [3:0]  byte_num;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e           state_q, state_d;
    cmd_t [1:0]       req_cmd;
    cmd_t             cmd_q;
    logic [1:0]       req;
    logic             win;
    logic             latch_en;
    logic             owner_q;
    logic             legal_q;
    logic             last_q;
    logic [1:0][31:0] rdata_q;
    logic [1:0]       gnt, rvalid, err;

    function automatic logic is_legal(cmd_t c);
        if (c.we) return |c.byte_num;
        return (c.byte_num == 4'b0001) || (c.byte_num == 4'b0011) || (c.byte_num == 4'b1111);
    endfunction

    assign req        = {m1.req, m0.req};
    assign req_cmd[0] = {m0.we, m0.ld_us, m0.byte_num, m0.addr, m0.wdata};
    assign req_cmd[1] = {m1.we, m1.ld_us, m1.byte_num, m1.addr, m1.wdata};

    // last_q holds the most recently granted requester; on conflict the other one wins
    always_comb begin
        win = req[1];
        if (req == 2'b11) win = RR_EN ? ~last_q : 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = (|req) ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign latch_en = (state_d == ISSUE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q   <= '0;
            owner_q <= 1'b0;
            legal_q <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            if (latch_en) begin
                cmd_q   <= req_cmd[win];
                owner_q <= win;
                legal_q <= is_legal(req_cmd[win]);
            end
            if (state_q == ISSUE) begin
                last_q           <= owner_q;
                rdata_q[owner_q] <= (!cmd_q.we && legal_q) ? lsu_ld_data_i : 32'h0;
            end
        end
    end

    always_comb begin
        gnt        = 2'b00;
        rvalid     = 2'b00;
        err        = 2'b00;
        lsu_sten_o = 1'b0;
        case (state_q)
            ISSUE: begin
                gnt[owner_q] = 1'b1;
                lsu_sten_o   = cmd_q.we & legal_q;
            end
            RESP: begin
                rvalid[owner_q] = 1'b1;
                err[owner_q]    = ~legal_q;
            end
            default: ;
        endcase
    end

    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    assign m0.rvalid = rvalid[0];
    assign m1.rvalid = rvalid[1];
    assign m0.err    = err[0];
    assign m1.err    = err[1];
    assign m0.rdata  = rdata_q[0];
    assign m1.rdata  = rdata_q[1];

    assign lsu_ld_us_o    = cmd_q.ld_us;
    assign lsu_byte_num_o = cmd_q.byte_num;
    assign lsu_addr_o     = cmd_q.addr;
    assign lsu_st_data_o  = cmd_q.wdata;

`ifdef LSU_ARB_STAT_EN
    logic [1:0][15:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (gnt[k] && cnt_q[k] != 16'hFFFF) cnt_q[k] <= cnt_q[k] + 16'd1;
        end
    end

    assign m0_cnt_o = cnt_q[0];
    assign m1_cnt_o = cnt_q[1];
`endif

endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Two-requester arbiter sharing the single LSU data port between the core load/store path (m0) and a secondary master such as a DMA or debug port (m1).
- Arbitrates, latches the winning command, and drives the LSU for exactly one cycle.
- Captures load data and returns it to the owning requester with a one-cycle response pulse.
- Sits between the requesters and the LSU; the LSU memory map and the load sign/zero extension live in the LSU.

Parameters:
RR_EN, 1, 1 = round-robin between m0/m1; 0 = fixed priority, m0 always wins.

Ports:
clk_i  input  1  clock, all state updates on posedge.
rst_ni  input  1  asynchronous active-low reset.
mK_req_i  input  1  (K=0,1) request; command fields held stable while high until mK_gnt_o.
mK_we_i  input  1  1 = store, 0 = load.
mK_ld_us_i  input  1  load unsigned.
mK_byte_num_i  input  4  byte enables: 0001, 0011 or 1111.
mK_addr_i  input  32  byte address.
mK_wdata_i  input  32  store data.
mK_gnt_o  output  1  command accepted, one-cycle pulse.
mK_rvalid_o  output  1  response valid, one-cycle pulse.
mK_rdata_o  output  32  load data, valid with rvalid.
mK_err_o  output  1  illegal byte_num, pulses with rvalid.
lsu_sten_o  output  1  LSU store enable.
lsu_ld_us_o  output  1  to LSU.
lsu_byte_num_o  output  4  to LSU.
lsu_addr_o  output  32  to LSU.
lsu_st_data_o  output  32  to LSU.
lsu_ld_data_i  input  32  extended load data from LSU (combinational).

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE; all outputs 0; command registers 0.
  - RR pointer favours m0.
  - Any in-flight transaction is dropped: no rvalid, and lsu_sten_o falls immediately.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if any req, arbitrate, latch the winner's command and owner, go to ISSUE; otherwise stay in IDLE.
  - ISSUE: mK_gnt_o=1 for the owner. LSU outputs come from the command registers.
    - lsu_sten_o = we & legal.
    - At the clock edge, capture rdata = (load & legal) ? lsu_ld_data_i : 0, then go to RESP.
  - RESP: owner's mK_rvalid_o=1, mK_rdata_o=captured value, mK_err_o=~legal.
    - Arbitrate in the same cycle: any req goes to ISSUE with the new winner latched; otherwise go to IDLE.
- Latency: req seen at cycle T -> gnt at T+1 -> rvalid at T+2. Back-to-back throughput is one transaction per 2 cycles.
- Requester rule: in the cycle after gnt, a requester must either deassert req or present a new command.
- Arbitration:
  - RR_EN=1: on a conflict, the requester not granted most recently wins; the pointer updates on each grant.
  - RR_EN=0: m0 always wins.
  - A single requester always wins.
- Legality: loads require byte_num ∈ {0001, 0011, 1111}; stores require byte_num ≠ 0000.
  - An illegal command is still granted, but lsu_sten_o stays 0, rdata=0 and err pulses.
- Register behaviour:
  - lsu_sten_o is high only in ISSUE.
  - lsu_addr/byte_num/ld_us/st_data hold the last command outside ISSUE.
  - mK_rdata_o holds its value between responses.
- Both requests rising in the same cycle is a normal conflict and is resolved by arbitration.
- No combinational path from mK_req_i to lsu_* outputs or to gnt.

Optional Feature:
- Macro: LSU_ARB_STAT_EN.
- Defined: adds outputs m0_cnt_o[15:0] and m1_cnt_o[15:0], 16-bit grant counters.
  - Each counter increments on its mK_gnt_o and saturates at 0xFFFF.
  - Both counters are cleared by reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single store: m0 store addr 0x10, wdata 0xDEADBEEF, byte_num 1111 at T -> m0_gnt_o at T+1; lsu_sten_o=1 only at T+1 with lsu_addr_o=0x10; m0_rvalid_o at T+2; m0_err_o=0.
- Round-robin: after reset, m0 and m1 both hold req continuously with RR_EN=1 -> grant order m0, m1, m0, m1 with gnt pulses 2 cycles apart; rvalid pulses alternate accordingly.
- Halfword load: m1 load, byte_num 0011, ld_us 1, lsu_ld_data_i=0x00008001 -> lsu_ld_us_o=1 and lsu_byte_num_o=0011 in ISSUE; m1_rdata_o=0x00008001 at rvalid.
- Illegal command: m0 load with byte_num 0010 -> gnt occurs; lsu_sten_o stays 0; m0_rvalid_o and m0_err_o pulse together; m0_rdata_o=0.
- Reset mid-operation: rst_ni=0 during ISSUE of a store -> lsu_sten_o drops immediately; no rvalid; after release, a conflict grants m0 first.
- Fixed priority: RR_EN=0 with both requesting continuously -> m0 granted every transaction and m1 never granted. With LSU_ARB_STAT_EN defined, after 3 transactions m0_cnt_o=3 and m1_cnt_o=0.
